// File: rtl/irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | irq_ctrl: edge-latched, masked, fixed-priority, non-nesting interrupt      |
// | sequencer driving the fetch-stage PC override.   Rev 1.0                   |
// +----------------------------------------------------------------------------+
module irq_ctrl #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_1000,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic [31:0]        resume_pc,
  input  logic               stall,
  input  logic               mret,
  output logic               interrupt_en,
  output logic [31:0]        interrupt_handling_addr,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_handler,
  output logic [31:0]        epc,
  output logic [3:0]         cause
);

  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HANDLER = 2'd1,
    ST_RETURN  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] irq_req_d;
  logic [31:0]        epc_q;
  logic [IDX_W-1:0]   cause_q;

  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] onehot;
  logic [NUM_IRQ-1:0] clr;
  logic [IDX_W-1:0]   idx;
  logic [31:0]        vector;
  logic               take;

  assign elig = pending & mask;

  // Descending scan so the lowest eligible index is the last (winning) write.
  always_comb begin
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) idx = IDX_W'(i);
    end
  end

  assign vector = VEC_BASE + VEC_STRIDE * {{(32-IDX_W){1'b0}}, idx};
  assign onehot = NUM_IRQ'(1) << idx;
  assign clr    = take ? onehot : '0;

  always_comb begin
    state_nx                = state;
    take                    = 1'b0;
    interrupt_en            = 1'b0;
    interrupt_handling_addr = 32'h0;
    irq_ack                 = '0;
    in_handler              = 1'b0;
    if (rst) begin
      case (state)
        ST_IDLE: begin
          take = (|elig) & ~stall;
          if (take) begin
            interrupt_en            = 1'b1;
            interrupt_handling_addr = vector;
            irq_ack                 = onehot;
            state_nx                = ST_HANDLER;
          end
        end
        ST_HANDLER: begin
          in_handler = 1'b1;
          if (mret && !stall) state_nx = ST_RETURN;
        end
        ST_RETURN: begin
          in_handler              = 1'b1;
          interrupt_en            = ~stall;
          interrupt_handling_addr = epc_q;
          if (!stall) state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  assign epc   = rst ? epc_q : 32'h0;
  assign cause = rst ? cause_q : '0;

  // A rising edge in the same cycle as the clear keeps the line pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pending   <= '0;
      mask      <= '0;
      irq_req_d <= '0;
      epc_q     <= 32'h0;
      cause_q   <= '0;
    end else begin
      state     <= state_nx;
      pending   <= (pending & ~clr) | (irq_req & ~irq_req_d);
      irq_req_d <= irq_req;
      if (mask_wr) mask <= mask_wdata;
      if (take) begin
        epc_q   <= resume_pc;
        cause_q <= idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_irq_ctrl: directed scenarios plus randomized traffic against a          |
// | behavioural model of the interrupt controller.   Rev 1.0                   |
// +----------------------------------------------------------------------------+
module tb_irq_ctrl;

  localparam int          NI = 4;
  localparam logic [31:0] VB = 32'h0000_1000;
  localparam logic [31:0] VS = 32'h0000_0010;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] irq_req;
  logic          mask_wr;
  logic [NI-1:0] mask_wdata;
  logic [31:0]   resume_pc;
  logic          stall;
  logic          mret;
  logic          interrupt_en;
  logic [31:0]   interrupt_handling_addr;
  logic [NI-1:0] irq_ack;
  logic          in_handler;
  logic [31:0]   epc;
  logic [3:0]    cause;

  irq_ctrl #(.NUM_IRQ(NI), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .irq_req                 (irq_req),
    .mask_wr                 (mask_wr),
    .mask_wdata              (mask_wdata),
    .resume_pc               (resume_pc),
    .stall                   (stall),
    .mret                    (mret),
    .interrupt_en            (interrupt_en),
    .interrupt_handling_addr (interrupt_handling_addr),
    .irq_ack                 (irq_ack),
    .in_handler              (in_handler),
    .epc                     (epc),
    .cause                   (cause)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: phase 0 = no handler, 1 = handler running, 2 = returning.
  bit          m_pend [NI];
  bit          m_prev [NI];
  bit          m_mask [NI];
  int          m_phase;
  logic [31:0] m_epc;
  int          m_cause;
  bit          e_take;
  int          e_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [NI-1:0] rq, input logic mw, input logic [NI-1:0] md,
                       input logic [31:0] pc, input logic st, input logic mr, input logic rs);
    logic        en;
    logic [31:0] addr;
    logic [31:0] ack;
    logic        inh;
    int          found;
    @(negedge clk);
    irq_req = rq; mask_wr = mw; mask_wdata = md; resume_pc = pc;
    stall = st; mret = mr; rst = rs;
    #1;
    e_take = 0; e_idx = 0; en = 0; addr = 0; ack = 0; inh = 0;
    if (rs) begin
      found = -1;
      for (int i = 0; i < NI; i++) begin
        if (m_pend[i] && m_mask[i]) begin
          found = i;
          break;
        end
      end
      if (m_phase == 0 && found >= 0 && !st) begin
        e_take = 1; e_idx = found; en = 1;
        addr = VB + VS * found;
        ack = 32'd1 << found;
      end else if (m_phase == 1) begin
        inh = 1;
      end else if (m_phase == 2) begin
        inh = 1; en = !st; addr = m_epc;
      end
    end
    chk("interrupt_en", {31'b0, interrupt_en}, {31'b0, en});
    chk("handler_addr", interrupt_handling_addr, addr);
    chk("irq_ack", {28'b0, irq_ack}, ack);
    chk("in_handler", {31'b0, in_handler}, {31'b0, inh});
    chk("epc", epc, rs ? m_epc : 32'h0);
    chk("cause", {28'b0, cause}, rs ? m_cause : 0);
  endtask

  task automatic adv();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        m_pend[i] = 0; m_prev[i] = 0; m_mask[i] = 0;
      end
      m_phase = 0; m_epc = 0; m_cause = 0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (e_take && i == e_idx) m_pend[i] = 0;
        if (irq_req[i] && !m_prev[i]) m_pend[i] = 1;
        m_prev[i] = irq_req[i];
        if (mask_wr) m_mask[i] = mask_wdata[i];
      end
      if (m_phase == 0 && e_take) begin
        m_phase = 1; m_epc = resume_pc; m_cause = e_idx;
      end else if (m_phase == 1 && mret && !stall) begin
        m_phase = 2;
      end else if (m_phase == 2 && !stall) begin
        m_phase = 0;
      end
    end
  endtask

  task automatic step(input logic [NI-1:0] rq, input logic st, input logic mr);
    drive(rq, 1'b0, 4'h0, 32'h0000_0300, st, mr, 1'b1);
    adv();
  endtask

  initial begin
    m_phase = 0; m_epc = 0; m_cause = 0;
    e_take = 0; e_idx = 0;
    irq_req = 0; mask_wr = 0; mask_wdata = 0; resume_pc = 0;
    stall = 0; mret = 0; rst = 0;

    // T1: reset with every request line high
    drive(4'hF, 0, 0, 0, 0, 0, 0); adv();
    drive(4'hF, 0, 0, 0, 0, 0, 0);
    chk("t1_en_in_reset", {31'b0, interrupt_en}, 32'd0);
    adv();
    drive(4'h0, 1, 4'hF, 32'h200, 0, 0, 1);
    chk("t1_en_after_rel", {31'b0, interrupt_en}, 32'd0);
    adv();

    // T2: basic take of line 2
    drive(4'b0100, 0, 0, 32'h200, 0, 0, 1); adv();
    drive(4'b0000, 0, 0, 32'h200, 0, 0, 1);
    chk("t2_en", {31'b0, interrupt_en}, 32'd1);
    chk("t2_addr", interrupt_handling_addr, 32'h1020);
    chk("t2_ack", {28'b0, irq_ack}, 32'b0100);
    adv();
    drive(4'b0000, 0, 0, 32'h204, 0, 0, 1);
    chk("t2_epc", epc, 32'h200);
    chk("t2_cause", {28'b0, cause}, 32'd2);
    chk("t2_in_handler", {31'b0, in_handler}, 32'd1);
    adv();
    step(0, 0, 1);
    drive(4'b0000, 0, 0, 32'h300, 0, 0, 1);
    chk("t2_ret_addr", interrupt_handling_addr, 32'h200);
    adv();

    // T3: priority, no nesting, back-to-back
    drive(4'b1010, 0, 0, 32'h400, 0, 0, 1); adv();
    drive(4'b0000, 0, 0, 32'h400, 0, 0, 1);
    chk("t3_addr_l1", interrupt_handling_addr, 32'h1010);
    adv();
    step(4'b0001, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 1);
    drive(4'b0000, 0, 0, 32'h500, 0, 0, 1);
    chk("t3_ret_addr", interrupt_handling_addr, 32'h400);
    adv();
    drive(4'b0000, 0, 0, 32'h500, 0, 0, 1);
    chk("t3_addr_l0", interrupt_handling_addr, 32'h1000);
    adv();
    step(0, 0, 1);
    step(0, 0, 0);
    drive(4'b0000, 0, 0, 32'h600, 0, 0, 1);
    chk("t3_addr_l3", interrupt_handling_addr, 32'h1030);
    adv();
    step(0, 0, 1);
    step(0, 0, 0);

    // T4: stall holds off take, mret and return
    step(4'b0010, 1, 0);
    for (int k = 0; k < 3; k++) begin
      drive(4'b0000, 0, 0, 32'h700, 1, 0, 1);
      chk("t4_stalled_en", {31'b0, interrupt_en}, 32'd0);
      adv();
    end
    drive(4'b0000, 0, 0, 32'h700, 0, 0, 1);
    chk("t4_unstall_en", {31'b0, interrupt_en}, 32'd1);
    adv();
    step(0, 1, 1);
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);

    // T5: masked line waits for the mask write
    drive(0, 1, 4'h0, 0, 0, 0, 1); adv();
    step(4'b0001, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);
    drive(4'b0000, 1, 4'b0001, 32'h800, 0, 0, 1);
    chk("t5_old_mask_en", {31'b0, interrupt_en}, 32'd0);
    adv();
    drive(4'b0000, 0, 0, 32'h800, 0, 0, 1);
    chk("t5_take_addr", interrupt_handling_addr, 32'h1000);
    adv();

    // T6: reset while the handler runs
    drive(0, 0, 0, 0, 0, 0, 0); adv();
    drive(0, 1, 4'hF, 0, 0, 1, 1);
    chk("t6_epc", epc, 32'h0);
    adv();
    step(0, 0, 1);
    step(0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom % 3 == 0) ? 4'($urandom) : irq_req,
            ($urandom % 16 == 0), 4'($urandom), $urandom,
            ($urandom % 4 == 0), ($urandom % 5 == 0), ($urandom % 150 != 0));
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
